// File: rtl/lane_motion_scheduler.sv
// lane_motion_scheduler: advances every lane position once per frame through one shared adder.
// Ports:
//   Clk, Reset_h            clock, synchronous active-high reset
//   frame_tick, run, clear  per-frame pulse, gameplay enable, reload of all lanes from lane_offset
//   lane_speed, lane_dir    per-lane speed (Q.FRAC_W px/frame) and direction (1 = +x)
//   lane_offset             per-lane start position in pixels
//   lane_pos, lane_step     integer lane positions, one-cycle pulse when a lane's integer position moved
//   busy, frame_done        scan in progress, one-cycle end-of-frame pulse
//   overrun                 sticky: a tick arrived while a scan was still running
module lane_motion_scheduler #(
  parameter int NUM_LANES = 10,
  parameter int SPEED_W   = 10,
  parameter int FRAC_W    = 4,
  parameter int POS_W     = 10,
  parameter int SCREEN_W  = 640
) (
  input  logic                         Clk,
  input  logic                         Reset_h,
  input  logic                         frame_tick,
  input  logic                         run,
  input  logic                         clear,
  input  logic [NUM_LANES*SPEED_W-1:0] lane_speed,
  input  logic [NUM_LANES-1:0]         lane_dir,
  input  logic [NUM_LANES*POS_W-1:0]   lane_offset,
  output logic [NUM_LANES*POS_W-1:0]   lane_pos,
  output logic [NUM_LANES-1:0]         lane_step,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);
  localparam int AW = POS_W + FRAC_W;
  localparam int IW = $clog2(NUM_LANES);
  localparam logic [AW:0] MOD = (AW+1)'(SCREEN_W << FRAC_W);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] idx;
  logic [AW-1:0] acc [NUM_LANES];
  logic [POS_W-1:0] offFix [NUM_LANES];
  logic [AW-1:0] curAcc, nxtAcc;
  logic [AW:0] sum, dif, nxt;
  logic stepNow, lastLane;
  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : gLane
      logic [POS_W-1:0] offRaw;
      assign offRaw = lane_offset[g*POS_W +: POS_W];
      // offsets up to one screen past the edge fold back onto the screen
      assign offFix[g] = offRaw >= POS_W'(SCREEN_W) ? offRaw - POS_W'(SCREEN_W) : offRaw;
      assign lane_pos[g*POS_W +: POS_W] = acc[g][AW-1:FRAC_W];
    end
  endgenerate
  // single shared datapath, selected by the lane currently being scanned
  always_comb begin
    curAcc = acc[idx];
    sum = {1'b0, curAcc} + (AW+1)'(lane_speed[idx*SPEED_W +: SPEED_W]);
    dif = {1'b0, curAcc} - (AW+1)'(lane_speed[idx*SPEED_W +: SPEED_W]);
    // dif[AW] is the borrow of the left move
    nxt = lane_dir[idx] ? (sum >= MOD ? sum - MOD : sum) : (dif[AW] ? dif + MOD : dif);
    nxtAcc = nxt[AW-1:0];
    stepNow = nxtAcc[AW-1:FRAC_W] != curAcc[AW-1:FRAC_W];
    lastLane = idx == IW'(NUM_LANES-1);
  end
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state <= IDLE;
      idx <= '0;
      lane_step <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) acc[i] <= '0;
    end else if (clear) begin
      state <= IDLE;
      idx <= '0;
      lane_step <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) acc[i] <= {offFix[i], FRAC_W'(0)};
    end else begin
      lane_step <= '0;
      if (frame_tick && state != IDLE) overrun <= 1'b1;
      if (state == IDLE && frame_tick && run) begin
        state <= SCAN;
        idx <= '0;
      end else if (state == SCAN) begin
        acc[idx] <= nxtAcc;
        lane_step[idx] <= stepNow;
        idx <= lastLane ? '0 : idx + 1'b1;
        state <= lastLane ? DONE : SCAN;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_lane_motion_scheduler.sv
// tb_lane_motion_scheduler: table-driven and scoreboard checks of lane motion, wrap and frame timing.
module tb_lane_motion_scheduler;
  logic Clk, Reset_h, frame_tick, run, clear;
  logic [99:0] speedV, offV, posV;
  logic [9:0] dirV, stepV;
  logic busy, frame_done, overrun;
  int checks = 0, errors = 0;
  typedef struct {int lane; int off; int sp; bit dir; int nt; int clr; int p1; bit s1; int p2; bit s2;} vec_t;
  typedef struct {int lane; int pos; bit step;} exp_t;
  vec_t vt[8];
  exp_t sb[$];
  lane_motion_scheduler dut (
    .Clk(Clk), .Reset_h(Reset_h), .frame_tick(frame_tick), .run(run), .clear(clear),
    .lane_speed(speedV), .lane_dir(dirV), .lane_offset(offV),
    .lane_pos(posV), .lane_step(stepV), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );
  initial Clk = 0;
  always #5 Clk = ~Clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int posOf(input int lane);
    return int'(posV[lane*10 +: 10]);
  endfunction
  task automatic setLane(input int lane, input int off, input int sp, input bit dir);
    offV[lane*10 +: 10] = 10'(off);
    speedV[lane*10 +: 10] = 10'(sp);
    dirV[lane] = dir;
  endtask
  task automatic pulseClear();
    @(negedge Clk) clear = 1;
    @(negedge Clk) clear = 0;
  endtask
  task automatic runFrame(input int lane, input int pos, input bit step);
    exp_t e;
    bit seen, done;
    seen = 0;
    done = 0;
    sb.push_back('{lane, pos, step});
    @(negedge Clk) frame_tick = 1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge Clk);
      frame_tick = 0;
      seen |= stepV[lane];
      done = frame_done;
    end
    e = sb.pop_front();
    if (!done) chk("frame_done_timeout", 0, 1);
    else begin
      chk($sformatf("pos_lane%0d", e.lane), posOf(e.lane), e.pos);
      chk($sformatf("step_lane%0d", e.lane), int'(seen), int'(e.step));
    end
  endtask
  initial begin
    vt[0] = '{0, 100, 'h018, 1'b1, 2, 100, 101, 1'b1, 103, 1'b1};
    vt[1] = '{0, 639, 'h010, 1'b1, 1, 639, 0, 1'b1, 0, 1'b0};
    vt[2] = '{0, 0, 'h010, 1'b0, 1, 0, 639, 1'b1, 0, 1'b0};
    vt[3] = '{0, 700, 'h010, 1'b1, 0, 60, 0, 1'b0, 0, 1'b0};
    vt[4] = '{9, 5, 'h3FF, 1'b0, 1, 5, 581, 1'b1, 0, 1'b0};
    vt[5] = '{5, 630, 'h0A0, 1'b1, 2, 630, 0, 1'b1, 10, 1'b1};
    vt[6] = '{3, 200, 'h008, 1'b1, 1, 200, 200, 1'b0, 0, 1'b0};
    vt[7] = '{7, 1023, 'h000, 1'b1, 1, 383, 383, 1'b0, 0, 1'b0};
    Reset_h = 1; frame_tick = 0; run = 1; clear = 0;
    speedV = '0; dirV = '0; offV = '0;
    setLane(0, 100, 'h018, 1);
    repeat (2) @(negedge Clk);
    chk("reset_pos", int'(posV != 0), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_step", int'(stepV), 0);
    chk("reset_done", int'(frame_done), 0);
    Reset_h = 0;
    for (int v = 0; v < 8; v++) begin
      speedV = '0; dirV = '0; offV = '0;
      setLane(vt[v].lane, vt[v].off, vt[v].sp, vt[v].dir);
      pulseClear();
      chk($sformatf("clear_pos_v%0d", v), posOf(vt[v].lane), vt[v].clr);
      if (vt[v].nt > 0) runFrame(vt[v].lane, vt[v].p1, vt[v].s1);
      if (vt[v].nt > 1) runFrame(vt[v].lane, vt[v].p2, vt[v].s2);
    end
    speedV = '0; dirV = '0; offV = '0;
    setLane(0, 0, 'h010, 1);
    setLane(9, 0, 'h010, 1);
    pulseClear();
    frame_tick = 1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge Clk);
      chk($sformatf("busy_c%0d", c), int'(busy), int'(c <= 11));
      chk($sformatf("done_c%0d", c), int'(frame_done), int'(c == 11));
      chk($sformatf("step9_c%0d", c), int'(stepV[9]), int'(c == 11));
      chk($sformatf("step0_c%0d", c), int'(stepV[0]), int'(c == 2));
      chk($sformatf("overrun_c%0d", c), int'(overrun), int'(c >= 6));
      frame_tick = (c == 5);
    end
    chk("timing_pos9", posOf(9), 1);
    pulseClear();
    chk("overrun_cleared", int'(overrun), 0);
    chk("reload_pos9", posOf(9), 0);
    frame_tick = 1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge Clk);
      frame_tick = 0;
      clear = (c == 4);
      if (c >= 5) begin
        chk($sformatf("abort_busy_c%0d", c), int'(busy), 0);
        chk($sformatf("abort_done_c%0d", c), int'(frame_done), 0);
      end
    end
    chk("abort_pos0", posOf(0), 0);
    chk("abort_pos9", posOf(9), 0);
    run = 0;
    @(negedge Clk) frame_tick = 1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge Clk);
      frame_tick = 0;
      chk($sformatf("norun_busy_c%0d", c), int'(busy), 0);
    end
    chk("norun_overrun", int'(overrun), 0);
    chk("norun_pos0", posOf(0), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
